muldiv_sequencer: RTL and testbench

//  Iterative 32-cycle multiply/divide unit with its own HI/LO registers and sequencing FSM.

---
 rtl/muldiv_pkg.sv | 30 +++
 rtl/muldiv_step.sv | 38 +++
 rtl/muldiv_sequencer.sv | 156 +++++++++++++++
 tb/tb_muldiv_sequencer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and small decode helpers for the iterative multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [1:0] {
        MULT  = 2'd0,
        MULTU = 2'd1,
        DIV   = 2'd2,
        DIVU  = 2'd3
    } mdop_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } mdstate_t;

    function automatic logic op_is_signed(input mdop_t op);
        return (op == MULT) || (op == DIV);
    endfunction

    function automatic logic op_is_div(input mdop_t op);
        return (op == DIV) || (op == DIVU);
    endfunction

    // D-stage decode helper: mfhi/mthi/mflo/mtlo/mult/multu/div/divu live in funct 0x10-0x1B.
    function automatic logic is_hilo_funct(input logic [5:0] funct);
        return (funct >= 6'h10) && (funct <= 6'h1B);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply or restoring subtract-shift divide
// on the {acc, q} pair against operand b.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             is_div_i,
    input  logic [WIDTH:0]   acc_i,
    input  logic [WIDTH-1:0] q_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH:0]   acc_o,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH:0]   sum;
    logic [WIDTH+1:0] diff;

    // The extra acc bit holds the add carry before it is shifted back down into range.
    assign sum  = acc_i + (q_i[0] ? {1'b0, b_i} : '0);
    assign diff = {1'b0, acc_i[WIDTH-1:0], q_i[WIDTH-1]} - {2'b00, b_i};

    always_comb begin
        if (is_div_i) begin
            if (diff[WIDTH+1]) begin
                acc_o = {acc_i[WIDTH-1:0], q_i[WIDTH-1]};
                q_o   = {q_i[WIDTH-2:0], 1'b0};
            end else begin
                acc_o = diff[WIDTH:0];
                q_o   = {q_i[WIDTH-2:0], 1'b1};
            end
        end else begin
            acc_o = {1'b0, sum[WIDTH:1]};
            q_o   = {sum[0], q_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative MIPS mult/multu/div/divu unit with HI/LO registers, sequencing FSM
// and the decode-stage stall for later HI/LO users.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             startE,
    input  logic             flushE,
    input  mdop_t            opE,
    input  logic [WIDTH-1:0] srcaE,
    input  logic [WIDTH-1:0] srcbE,
    input  logic             hiloD,
    input  logic             wehiW,
    input  logic             weloW,
    input  logic [WIDTH-1:0] wdW,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             stallmdD,
    output logic             doneM
);

    localparam int CW = $clog2(WIDTH);

    mdstate_t         state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    mdop_t            op_q, op_d;
    logic             sign_a_q, sign_a_d, sign_b_q, sign_b_d;
    logic [WIDTH:0]   acc_q, acc_d;
    logic [WIDTH-1:0] q_q, q_d, b_q, b_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;

    logic [WIDTH:0]     step_acc;
    logic [WIDTH-1:0]   step_q;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo, rem, res_hi, res_lo;
    logic               start_sign_a, start_sign_b;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div_i (op_is_div(op_q)),
        .acc_i    (acc_q),
        .q_i      (q_q),
        .b_i      (b_q),
        .acc_o    (step_acc),
        .q_o      (step_q)
    );

    assign start_sign_a = op_is_signed(opE) & srcaE[WIDTH-1];
    assign start_sign_b = op_is_signed(opE) & srcbE[WIDTH-1];

    // Sign fix-up: the core only ever works on magnitudes.
    always_comb begin
        prod = {acc_q[WIDTH-1:0], q_q};
        quo  = q_q;
        rem  = acc_q[WIDTH-1:0];
        if (op_q == MULT && (sign_a_q ^ sign_b_q)) prod = -prod;
        if (op_q == DIV && (sign_a_q ^ sign_b_q))  quo  = -quo;
        if (op_q == DIV && sign_a_q)               rem  = -rem;
        if (op_is_div(op_q)) begin
            res_hi = rem;
            res_lo = quo;
        end else begin
            res_hi = prod[2*WIDTH-1:WIDTH];
            res_lo = prod[WIDTH-1:0];
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        op_d     = op_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        acc_d    = acc_q;
        q_d      = q_q;
        b_d      = b_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        unique case (state_q)
            IDLE: begin
                if (wehiW) hi_d = wdW;
                if (weloW) lo_d = wdW;
                if (startE && !flushE) begin
                    op_d     = opE;
                    sign_a_d = start_sign_a;
                    sign_b_d = start_sign_b;
                    q_d      = start_sign_a ? -srcaE : srcaE;
                    b_d      = start_sign_b ? -srcbE : srcbE;
                    acc_d    = '0;
                    count_d  = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                acc_d = step_acc;
                q_d   = step_q;
                if (count_q == CW'(WIDTH - 1)) begin
                    state_d = FIX;
                end else begin
                    count_d = count_q + CW'(1);
                end
            end
            FIX: begin
                // A same-cycle mthi/mtlo overrides the finishing result for that half.
                hi_d    = wehiW ? wdW : res_hi;
                lo_d    = weloW ? wdW : res_lo;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            op_q     <= MULT;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            acc_q    <= '0;
            q_q      <= '0;
            b_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            op_q     <= op_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            acc_q    <= acc_d;
            q_q      <= q_d;
            b_q      <= b_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign hi       = hi_q;
    assign lo       = lo_q;
    assign busy     = (state_q != IDLE);
    assign stallmdD = busy & hiloD;
    assign doneM    = (state_q == FIX);

    a_no_start_while_busy : assert property (
        @(posedge clk) disable iff (!reset) !(startE && !flushE && busy));

    a_no_mt_at_finish : assert property (
        @(posedge clk) disable iff (!reset) !((state_q == FIX) && (wehiW || weloW)));

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Randomised scoreboard bench for muldiv_sequencer against an arithmetic reference model.
module tb_muldiv_sequencer;
    import muldiv_pkg::*;

    localparam int WIDTH = 32;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        startE = 1'b0, flushE = 1'b0, hiloD = 1'b0;
    logic        wehiW = 1'b0, weloW = 1'b0;
    mdop_t       opE = MULT;
    logic [31:0] srcaE = '0, srcbE = '0, wdW = '0;
    logic [31:0] hi, lo;
    logic        busy, stallmdD, doneM;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [63:0] exp;
        int          start;
        string       name;
    } item_t;

    item_t sb_q[$];

    muldiv_sequencer #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .startE   (startE),
        .flushE   (flushE),
        .opE      (opE),
        .srcaE    (srcaE),
        .srcbE    (srcbE),
        .hiloD    (hiloD),
        .wehiW    (wehiW),
        .weloW    (weloW),
        .wdW      (wdW),
        .hi       (hi),
        .lo       (lo),
        .busy     (busy),
        .stallmdD (stallmdD),
        .doneM    (doneM)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference: {hi, lo} straight from MIPS arithmetic semantics.
    function automatic logic [63:0] model(input mdop_t op, input logic [31:0] a, input logic [31:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint qq, rr;
        logic [63:0] ua = {32'b0, a};
        logic [63:0] ub = {32'b0, b};
        logic [63:0] r;
        case (op)
            MULT:  r = 64'(sa * sb);
            MULTU: r = ua * ub;
            DIV: begin
                qq = sa / sb;
                rr = sa % sb;
                r  = {rr[31:0], qq[31:0]};
            end
            default: begin
                if (b == 0) r = {a, 32'hFFFF_FFFF};
                else        r = {a % b, a / b};
            end
        endcase
        return r;
    endfunction

    task automatic wait_idle();
        @(negedge clk);
        for (int i = 0; i < 200 && busy; i++) @(negedge clk);
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL wait_idle: busy stuck high");
        end
    endtask

    task automatic issue(input mdop_t op, input logic [31:0] a, input logic [31:0] b,
                         input bit push, input string name);
        wait_idle();
        opE    = op;
        srcaE  = a;
        srcbE  = b;
        startE = 1'b1;
        @(posedge clk);
        #1;
        startE = 1'b0;
        if (push) sb_q.push_back('{model(op, a, b), cyc, name});
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && sb_q.size() != 0; i++) @(negedge clk);
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d results never arrived", sb_q.size());
        end
        repeat (3) @(negedge clk);
    endtask

    // Monitor: every doneM pulse must match the oldest outstanding operation.
    always begin
        item_t it;
        @(negedge clk);
        if (doneM) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected doneM at cycle %0d", cyc);
            end else begin
                it = sb_q.pop_front();
                check({it.name, " latency"}, 64'(cyc - it.start), 64'(WIDTH));
                @(posedge clk);
                #1;
                check({it.name, " hi/lo"}, {hi, lo}, it.exp);
                @(negedge clk);
                check({it.name, " doneM width"}, 64'(doneM), 64'(0));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        logic [31:0] ra, rb;
        mdop_t rop;

        #1;
        check("reset hi/lo", {hi, lo}, 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset doneM", 64'(doneM), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        issue(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, "multu max");
        issue(MULT,  -32'sd7, 32'd3, 1, "mult -7*3");
        issue(DIV,   -32'sd7, 32'd2, 1, "div -7/2");
        issue(DIVU,  32'd100, 32'd0, 1, "divu by zero");
        issue(DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1, "div overflow");
        drain();

        // Stall follows busy while a HI/LO user sits in decode.
        issue(MULTU, 32'd5, 32'd7, 1, "multu stall");
        hiloD = 1'b1;
        seen  = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            check("stall while busy", 64'(stallmdD), 64'd1);
            if (doneM) seen = 1'b1;
        end
        check("stall op finished", 64'(seen), 64'd1);
        @(negedge clk);
        check("stall after doneM", 64'(stallmdD), 64'd0);
        hiloD = 1'b0;
        drain();

        // A flushed start never launches.
        opE = DIVU; srcaE = 32'd9; srcbE = 32'd3;
        startE = 1'b1; flushE = 1'b1;
        @(posedge clk);
        #1;
        startE = 1'b0; flushE = 1'b0;
        check("flushed start busy", 64'(busy), 64'd0);
        repeat (3) @(negedge clk);
        check("flushed start still idle", 64'(busy), 64'd0);

        // mthi / mtlo in IDLE.
        @(negedge clk);
        wehiW = 1'b1; wdW = 32'h0000_1234;
        @(posedge clk);
        #1;
        wehiW = 1'b0;
        check("mthi", 64'(hi), 64'h1234);
        @(negedge clk);
        weloW = 1'b1; wdW = 32'h0000_5678;
        @(posedge clk);
        #1;
        weloW = 1'b0;
        check("mtlo hi/lo", {hi, lo}, 64'h0000_1234_0000_5678);

        // Reset mid-RUN aborts without a doneM.
        issue(MULT, -32'sd7, 32'd3, 0, "aborted");
        repeat (10) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("abort busy", 64'(busy), 64'd0);
        check("abort hi/lo", {hi, lo}, 64'd0);
        check("abort doneM", 64'(doneM), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        issue(DIVU, 32'd1000, 32'd7, 1, "after abort");

        // Back-to-back operations.
        issue(MULT, 32'd12345, -32'sd678, 1, "b2b first");
        issue(DIV,  -32'sd1000, -32'sd33, 1, "b2b second");
        drain();

        for (int n = 0; n < 16; n++) begin
            rop = mdop_t'($urandom_range(0, 3));
            ra  = ($urandom_range(0, 3) == 0) ? 32'($signed($urandom_range(0, 40)) - 20) : $urandom;
            rb  = ($urandom_range(0, 3) == 0) ? 32'($signed($urandom_range(0, 40)) - 20) : $urandom;
            if ($urandom_range(0, 2) == 0) rb = rb >> $urandom_range(1, 31);
            if (rop == DIV && rb == 0) rb = 32'd1;
            issue(rop, ra, rb, 1, $sformatf("random %0d", n));
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
